// File: rtl/dmem_port_arb.sv
// Two-requester (LSU, TLB) arbiter onto one split-handshake data memory port,
// with an in-order response queue. Define DMEM_ARB_RR_EN for round-robin ties.
module dmem_port_arb #(
    parameter int GRLEN      = 32,
    parameter int OUTQ_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             change,
    input  logic             lsu_req,
    input  logic [GRLEN-1:0] lsu_addr,
    input  logic             lsu_wr,
    input  logic [3:0]       lsu_wstrb,
    input  logic [GRLEN-1:0] lsu_wdata,
    output logic             lsu_addr_ok,
    output logic             lsu_data_ok,
    output logic [GRLEN-1:0] lsu_rdata,
    input  logic             tlb_req,
    input  logic [GRLEN-1:0] tlb_addr,
    input  logic             tlb_wr,
    input  logic [3:0]       tlb_wstrb,
    input  logic [GRLEN-1:0] tlb_wdata,
    output logic             tlb_addr_ok,
    output logic             tlb_data_ok,
    output logic [GRLEN-1:0] tlb_rdata,
    output logic             data_req,
    output logic [GRLEN-1:0] data_addr,
    output logic             data_wr,
    output logic [3:0]       data_wstrb,
    output logic [GRLEN-1:0] data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    input  logic [GRLEN-1:0] data_rdata,
    output logic             arb_err
);
    localparam int PW = $clog2(OUTQ_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, LOCK_LSU = 2'd1, LOCK_TLB = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   count;
    logic [PW-1:0]   rptr, wptr;
    logic [OUTQ_DEPTH-1:0] q_tlb, q_kill;

    logic lsu_eff, blocked, sel_tlb, tie_tlb, hs, push, pop, q_empty;

    assign lsu_eff = lsu_req & ~change;
    assign blocked = (count == CW'(OUTQ_DEPTH));
    assign q_empty = (count == '0);
    assign hs      = data_req & data_addr_ok;
    assign push    = hs;
    assign pop     = data_data_ok & ~q_empty & ~rst;

`ifdef DMEM_ARB_RR_EN
    logic last_grant_tlb;
    always_ff @(posedge clk) begin
        if (rst)     last_grant_tlb <= 1'b1;
        else if (hs) last_grant_tlb <= sel_tlb;
    end
    assign tie_tlb = ~last_grant_tlb;
`else
    assign tie_tlb = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A lock is held until the handshake completes or the owner withdraws.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (data_req && !data_addr_ok) state_nxt = sel_tlb ? LOCK_TLB : LOCK_LSU;
            LOCK_LSU: if (hs || !lsu_eff) state_nxt = IDLE;
            LOCK_TLB: if (hs || !tlb_req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sel_tlb = 1'b0;
        case (state)
            LOCK_LSU: sel_tlb = 1'b0;
            LOCK_TLB: sel_tlb = 1'b1;
            default:  sel_tlb = (lsu_eff && tlb_req) ? tie_tlb : tlb_req;
        endcase
        data_req    = ~rst & ~blocked & (sel_tlb ? tlb_req : lsu_eff);
        data_addr   = sel_tlb ? tlb_addr  : lsu_addr;
        data_wr     = sel_tlb ? tlb_wr    : lsu_wr;
        data_wstrb  = sel_tlb ? tlb_wstrb : lsu_wstrb;
        data_wdata  = sel_tlb ? tlb_wdata : lsu_wdata;
        lsu_addr_ok = hs & ~sel_tlb;
        tlb_addr_ok = hs &  sel_tlb;
        tlb_data_ok = pop &  q_tlb[rptr];
        lsu_data_ok = pop & ~q_tlb[rptr] & ~q_kill[rptr];
    end

    assign lsu_rdata = data_rdata;
    assign tlb_rdata = data_rdata;

    // Flush marks queued LSU entries so their responses are swallowed in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            rptr    <= '0;
            wptr    <= '0;
            q_tlb   <= '0;
            q_kill  <= '0;
            arb_err <= 1'b0;
        end else begin
            for (int i = 0; i < OUTQ_DEPTH; i++)
                if (change && !q_tlb[i]) q_kill[i] <= 1'b1;
            if (push) begin
                q_tlb[wptr]  <= sel_tlb;
                q_kill[wptr] <= 1'b0;
                wptr         <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (data_data_ok && q_empty) arb_err <= 1'b1;
        end
    end
endmodule
